// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg: op codes, scheduler states and latency defaults for the MD unit.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package md_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } md_entry_t;

  // NOP and the reserved code never occupy a queue slot.
  function automatic logic is_queued_op(input logic [2:0] op);
    return (op != OP_NOP) && (op != OP_RSVD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_arith.sv
// ---------------------------------------------------------------------------
// md_arith: combinational multiply/divide core producing {hi,lo} and a keep flag.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_r_o,
  output logic [31:0] lo_r_o,
  output logic        keep_o
);

  logic [63:0] w_a_sx, w_b_sx, w_a_zx, w_b_zx;
  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_b_nz, w_mag_a, w_mag_b;
  logic [31:0] w_sq, w_sr, w_uq, w_ur;

  assign w_a_sx   = {{32{a_i[31]}}, a_i};
  assign w_b_sx   = {{32{b_i[31]}}, b_i};
  assign w_a_zx   = {32'd0, a_i};
  assign w_b_zx   = {32'd0, b_i};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = w_a_zx * w_b_zx;

  // Divisor forced non-zero so the datapath never sees x/0; keep_o masks it.
  // Magnitude division sidesteps the 0x80000000 / -1 overflow case.
  assign w_b_nz  = (b_i == 32'd0) ? 32'd1 : b_i;
  assign w_mag_a = a_i[31] ? (~a_i + 32'd1) : a_i;
  assign w_mag_b = w_b_nz[31] ? (~w_b_nz + 32'd1) : w_b_nz;
  assign w_sq    = w_mag_a / w_mag_b;
  assign w_sr    = w_mag_a % w_mag_b;
  assign w_uq    = a_i / w_b_nz;
  assign w_ur    = a_i % w_b_nz;

  always_comb begin
    hi_r_o = 32'd0;
    lo_r_o = 32'd0;
    keep_o = 1'b0;
    case (op_i)
      OP_MULT:  {hi_r_o, lo_r_o} = w_prod_s;
      OP_MULTU: {hi_r_o, lo_r_o} = w_prod_u;
      OP_DIV: begin
        keep_o = (b_i == 32'd0);
        lo_r_o = (a_i[31] ^ w_b_nz[31]) ? (~w_sq + 32'd1) : w_sq;
        hi_r_o = a_i[31] ? (~w_sr + 32'd1) : w_sr;
      end
      OP_DIVU: begin
        keep_o = (b_i == 32'd0);
        lo_r_o = w_uq;
        hi_r_o = w_ur;
      end
      default: keep_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/md_scheduler.sv
// ---------------------------------------------------------------------------
// md_scheduler: HI/LO owner; queues MD ops and commits them after a fixed latency.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module md_scheduler
  import md_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        in_valid,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        in_ready,
  input  logic        rd_valid,
  input  logic        rd_sel,
  output logic        rd_stall,
  output logic [31:0] rd_data,
  output logic        busy
);

  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAXLAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  md_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]     occ_q, occ_d;
  logic            full_q, full_d;
  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  md_entry_t       iss_q, iss_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;

  logic            w_push, w_pop, w_keep;
  logic [31:0]     w_hi_r, w_lo_r;
  md_entry_t       w_head, w_in;

  md_arith u_arith (
    .op_i   (iss_q.op),
    .a_i    (iss_q.a),
    .b_i    (iss_q.b),
    .hi_r_o (w_hi_r),
    .lo_r_o (w_lo_r),
    .keep_o (w_keep)
  );

  assign w_in     = '{op: in_op, a: in_a, b: in_b};
  assign w_head   = mem_q[rd_ptr_q];
  assign in_ready = !full_q && !req;
  assign w_push   = in_valid && in_ready && is_queued_op(in_op);
  assign w_pop    = (state_q == ST_IDLE) && (occ_q != '0);
  assign busy     = (occ_q != '0) || (state_q == ST_WAIT);
  assign rd_stall = rd_valid && busy;
  assign rd_data  = rd_valid ? (rd_sel ? hi_q : lo_q) : 32'd0;

  always_comb begin
    wr_ptr_d = w_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    occ_d    = occ_q;
    if (w_push && !w_pop) occ_d = occ_q + (PW+1)'(1);
    if (w_pop && !w_push) occ_d = occ_q - (PW+1)'(1);
    full_d   = (occ_d == (PW+1)'(DEPTH));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    iss_d    = iss_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    rd_ptr_d = rd_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (w_pop) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          case (w_head.op)
            OP_MTHI: hi_d = w_head.a;
            OP_MTLO: lo_d = w_head.a;
            OP_DIV, OP_DIVU: begin
              iss_d   = w_head;
              cnt_d   = CW'(DIV_LAT);
              state_d = ST_WAIT;
            end
            default: begin
              iss_d   = w_head;
              cnt_d   = CW'(MULT_LAT);
              state_d = ST_WAIT;
            end
          endcase
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          if (!w_keep) begin
            hi_d = w_hi_r;
            lo_d = w_lo_r;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      full_q   <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      iss_q    <= '0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      full_q   <= full_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      iss_q    <= iss_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Slot contents are qualified by occupancy, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= w_in;
  end

endmodule

`default_nettype wire

// File: tb/tb_md_scheduler.sv
// ---------------------------------------------------------------------------
// tb_md_scheduler: directed + random stimulus against an edge-timed reference model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_md_scheduler;

  localparam int DEPTH    = 2;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_op = 3'd0;
  logic [31:0] in_a = 32'd0, in_b = 32'd0;
  logic        in_ready;
  logic        rd_valid = 1'b0;
  logic        rd_sel = 1'b0;
  logic        rd_stall;
  logic [31:0] rd_data;
  logic        busy;

  md_scheduler #(.DEPTH(DEPTH), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .in_valid(in_valid), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_ready(in_ready), .rd_valid(rd_valid),
    .rd_sel(rd_sel), .rd_stall(rd_stall), .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } ent_t;

  // Model: pending queue, one in-flight op with an absolute commit edge.
  ent_t        mq[$];
  bit          m_infl;
  int          m_done;
  int          m_edge;
  logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;
  bit          m_res_keep;
  bit          m_enq;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_result(input ent_t e, output logic [31:0] hi, output logic [31:0] lo,
                              output bit keep);
    longint sa, sb, ua, ub, p, q, r;
    sa = longint'($signed(e.a));
    sb = longint'($signed(e.b));
    ua = longint'({32'd0, e.a});
    ub = longint'({32'd0, e.b});
    keep = 1'b0;
    p = 0; q = 0; r = 0;
    case (e.op)
      3'd1: p = sa * sb;
      3'd2: p = ua * ub;
      3'd3: if (e.b == 0) keep = 1'b1; else begin q = sa / sb; r = sa % sb; end
      3'd4: if (e.b == 0) keep = 1'b1; else begin q = ua / ub; r = ua % ub; end
      default: keep = 1'b1;
    endcase
    if (e.op == 3'd1 || e.op == 3'd2) begin
      hi = p[63:32];
      lo = p[31:0];
    end else begin
      hi = r[31:0];
      lo = q[31:0];
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_infl = 1'b0;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
  endtask

  task automatic step(input logic iv, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic rq, input logic rv, input logic rs);
    bit   m_ready, m_busy;
    ent_t h, e;
    int   nxt;
    @(negedge clk);
    in_valid = iv; in_op = op; in_a = a; in_b = b; req = rq; rd_valid = rv; rd_sel = rs;
    #1;
    m_ready = (mq.size() < DEPTH) && !rq;
    m_busy  = (mq.size() != 0) || m_infl;
    check("in_ready", in_ready, m_ready);
    check("busy", busy, m_busy);
    check("rd_stall", rd_stall, rv && m_busy);
    if (!rv) check("rd_data_idle", rd_data, 0);
    else if (!m_busy) check("rd_data", rd_data, rs ? m_hi : m_lo);
    nxt   = m_edge + 1;
    m_enq = iv && m_ready && (op != 3'd0) && (op != 3'd7);
    if (m_infl) begin
      if (nxt == m_done) begin
        m_infl = 1'b0;
        if (!m_res_keep) begin m_hi = m_res_hi; m_lo = m_res_lo; end
      end
    end else if (mq.size() != 0) begin
      h = mq.pop_front();
      if (h.op == 3'd5) m_hi = h.a;
      else if (h.op == 3'd6) m_lo = h.a;
      else begin
        m_infl = 1'b1;
        m_done = nxt + ((h.op == 3'd3 || h.op == 3'd4) ? DIV_LAT : MULT_LAT);
        model_result(h, m_res_hi, m_res_lo, m_res_keep);
      end
    end
    if (m_enq) begin
      e.op = op; e.a = a; e.b = b;
      mq.push_back(e);
    end
    m_edge = nxt;
  endtask

  task automatic push_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step(1'b1, op, a, b, 1'b0, 1'b0, 1'b0);
      done = m_enq;
    end
    if (!done) check("push_timeout", 0, 1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while ((mq.size() != 0 || m_infl) && n < 100) begin
      step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, n[0]);
      n++;
    end
    if (n >= 100) check("idle_timeout", 0, 1);
  endtask

  task automatic read_chk(input logic sel, input logic [31:0] exp, input string tag);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, sel);
    check(tag, rd_data, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; req = 1'b0; rd_valid = 1'b1; rd_sel = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_stall", rd_stall, 0);
    check("rst_rd_data", rd_data, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'd7;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    m_edge = 0;
    model_reset();
    do_reset();

    // MULT -3 * 7, commit LAT edges after the pop
    push_op(3'd1, 32'hFFFF_FFFD, 32'd7);
    wait_idle(n);
    check("mult_latency", n, MULT_LAT + 1);
    read_chk(1'b0, 32'hFFFF_FFEB, "mult_lo");
    read_chk(1'b1, 32'hFFFF_FFFF, "mult_hi");

    push_op(3'd3, 32'd7, 32'hFFFF_FFFE);
    wait_idle(n);
    check("div_latency", n, DIV_LAT + 1);
    read_chk(1'b0, 32'hFFFF_FFFD, "div_lo");
    read_chk(1'b1, 32'd1, "div_hi");
    push_op(3'd4, 32'd7, 32'd0);
    wait_idle(n);
    check("divz_latency", n, DIV_LAT + 1);
    read_chk(1'b0, 32'hFFFF_FFFD, "divz_lo");
    read_chk(1'b1, 32'd1, "divz_hi");

    // Fill the queue behind an in-flight op so the last push is held
    push_op(3'd1, 32'd3, 32'd3);
    push_op(3'd2, 32'hFFFF_FFFF, 32'd2);
    push_op(3'd6, 32'd5, 32'd0);
    check("full_seen", (mq.size() == DEPTH), 1);
    push_op(3'd5, 32'd9, 32'd0);
    wait_idle(n);
    read_chk(1'b0, 32'd5, "mt_lo");
    read_chk(1'b1, 32'd9, "mt_hi");

    step(1'b1, 3'd1, 32'd2, 32'd3, 1'b1, 1'b0, 1'b0);
    check("req_no_enq", m_enq, 0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    read_chk(1'b0, 32'd5, "req_lo");

    push_op(3'd1, 32'd4, 32'd4);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    do_reset();
    read_chk(1'b1, 32'd0, "post_rst_hi");
    check("post_rst_stall", rd_stall, 0);

    push_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    read_chk(1'b0, 32'h8000_0000, "ovf_lo");
    read_chk(1'b1, 32'd0, "ovf_hi");

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 1), 3'($urandom_range(0, 7)), rnd_val(), rnd_val(),
                ($urandom_range(0, 7) == 0), $urandom_range(0, 1), $urandom_range(0, 1));
    end
    wait_idle(n);
    read_chk(1'b0, m_lo, "final_lo");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
